// File: rtl/spi_frame_pkg.sv
// -----------------------------------------------------------------------------
// spi_frame_pkg
// Shared definitions for the SPI ASCII frame decoder and its future encoder
// counterpart: default framing characters, the 3-bit error class codes
// reported to the command/register layer, and the decoder state type.
// -----------------------------------------------------------------------------
package spi_frame_pkg;

    // Default framing characters: '#' opens a frame, '/' closes it.
    localparam logic [7:0] SOF_CHAR_DEF  = 8'h23;
    localparam logic [7:0] EOF_CHAR_DEF  = 8'h2F;
    localparam int         MAX_BYTES_DEF = 64;

    // Error class codes; ERR_NONE is only ever seen straight out of reset.
    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CHAR    = 3'd1;
    localparam logic [2:0] ERR_ODD     = 3'd2;
    localparam logic [2:0] ERR_LEN     = 3'd3;
    localparam logic [2:0] ERR_EMPTY   = 3'd4;
    localparam logic [2:0] ERR_ABORT   = 3'd5;
    localparam logic [2:0] ERR_RESTART = 3'd6;

    // IDLE: hunting for SOF; HI: expecting a high nibble or EOF;
    // LO: expecting the low nibble that completes a byte.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } state_e;

endpackage

// File: rtl/ascii_hex_nibble.sv
// -----------------------------------------------------------------------------
// ascii_hex_nibble
// Purely combinational ASCII hex digit classifier. Accepts '0'-'9', 'A'-'F'
// and 'a'-'f'; every other character reports isHex_o = 0 and nibble_o = 0.
// Ports:
//   char_i   in  8  ASCII character
//   isHex_o  out 1  character is a hex digit
//   nibble_o out 4  binary value of the digit (0 when not hex)
// -----------------------------------------------------------------------------
module ascii_hex_nibble (
    input  logic [7:0] char_i,
    output logic       isHex_o,
    output logic [3:0] nibble_o
);

    // Letters A-F and a-f share the same low bits (1..6), so adding 9 to the
    // low nibble maps both cases onto 10..15.
    always_comb begin
        isHex_o  = 1'b0;
        nibble_o = 4'h0;
        if (char_i >= 8'h30 && char_i <= 8'h39) begin
            isHex_o  = 1'b1;
            nibble_o = char_i[3:0];
        end else if ((char_i >= 8'h41 && char_i <= 8'h46) ||
                     (char_i >= 8'h61 && char_i <= 8'h66)) begin
            isHex_o  = 1'b1;
            nibble_o = char_i[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/spi_ascii_frame_decoder.sv
// -----------------------------------------------------------------------------
// spi_ascii_frame_decoder
// Sits behind the SPI slave byte receiver and extracts ASCII frames of the
// form '#' <hex pairs> '/'. Each hex pair becomes one binary byte on a
// registered stream with SOF/EOF markers. A one-byte hold register delays
// every byte until the next one (or EOF) arrives so that EOF can be attached
// to the true last byte. Frame completion, length and error class are
// reported upward. There is no backpressure.
// Ports:
//   CLK_I        in  1  clock
//   RST_I        in  1  synchronous active-high reset
//   RX_BYTE_I    in  8  received SPI byte
//   RX_VALID_I   in  1  RX_BYTE_I valid pulse
//   CS_RISE_I    in  1  SPI chip-select deassert pulse (transaction end)
//   M_DATA_O     out 8  decoded byte
//   M_VALID_O    out 1  decoded byte valid pulse
//   M_SOF_O      out 1  first byte of frame (qualifies M_VALID_O)
//   M_EOF_O      out 1  last byte of frame (qualifies M_VALID_O)
//   FRAME_DONE_O out 1  good-frame pulse, coincides with the EOF beat
//   FRAME_LEN_O  out 8  decoded byte count of the last good frame
//   FRAME_ERR_O  out 1  dropped-frame pulse
//   ERR_CODE_O   out 3  class of the last dropped frame
//   BUSY_O       out 1  decoder is inside a frame
// -----------------------------------------------------------------------------
module spi_ascii_frame_decoder
    import spi_frame_pkg::*;
#(
    parameter int         MAX_BYTES = MAX_BYTES_DEF,
    parameter logic [7:0] SOF_CHAR  = SOF_CHAR_DEF,
    parameter logic [7:0] EOF_CHAR  = EOF_CHAR_DEF
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic [7:0] RX_BYTE_I,
    input  logic       RX_VALID_I,
    input  logic       CS_RISE_I,
    output logic [7:0] M_DATA_O,
    output logic       M_VALID_O,
    output logic       M_SOF_O,
    output logic       M_EOF_O,
    output logic       FRAME_DONE_O,
    output logic [7:0] FRAME_LEN_O,
    output logic       FRAME_ERR_O,
    output logic [2:0] ERR_CODE_O,
    output logic       BUSY_O
);

    // Nine bits so that count+1 never wraps before the length check.
    localparam logic [8:0] MAX_LIMIT = 9'(MAX_BYTES);

    state_e     state_q, state_d;
    logic [3:0] nibHi_q, nibHi_d;
    logic [7:0] hold_q, hold_d;
    logic       holdValid_q, holdValid_d;
    logic       holdFirst_q, holdFirst_d;
    logic [7:0] count_q, count_d;

    logic [7:0] mData_q, mData_d;
    logic       mValid_q, mValid_d;
    logic       mSof_q, mSof_d;
    logic       mEof_q, mEof_d;
    logic       frameDone_q, frameDone_d;
    logic [7:0] frameLen_q, frameLen_d;
    logic       frameErr_q, frameErr_d;
    logic [2:0] errCode_q, errCode_d;

    logic       isHex;
    logic [3:0] nibble;
    logic       errHit;
    logic [2:0] errSel;
    logic [8:0] newCount;

    ascii_hex_nibble uHexNibble (
        .char_i   (RX_BYTE_I),
        .isHex_o  (isHex),
        .nibble_o (nibble)
    );

    // All state and output registers. Reset returns to IDLE with an empty
    // hold register and every output cleared, discarding any partial frame.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= ST_IDLE;
            nibHi_q     <= 4'h0;
            hold_q      <= 8'h00;
            holdValid_q <= 1'b0;
            holdFirst_q <= 1'b0;
            count_q     <= 8'h00;
            mData_q     <= 8'h00;
            mValid_q    <= 1'b0;
            mSof_q      <= 1'b0;
            mEof_q      <= 1'b0;
            frameDone_q <= 1'b0;
            frameLen_q  <= 8'h00;
            frameErr_q  <= 1'b0;
            errCode_q   <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            nibHi_q     <= nibHi_d;
            hold_q      <= hold_d;
            holdValid_q <= holdValid_d;
            holdFirst_q <= holdFirst_d;
            count_q     <= count_d;
            mData_q     <= mData_d;
            mValid_q    <= mValid_d;
            mSof_q      <= mSof_d;
            mEof_q      <= mEof_d;
            frameDone_q <= frameDone_d;
            frameLen_q  <= frameLen_d;
            frameErr_q  <= frameErr_d;
            errCode_q   <= errCode_d;
        end
    end

    // Next-state and output decode. The byte is processed first; a CS rise
    // in the same cycle then aborts only if the byte left us inside a frame,
    // so '/' together with CS completes cleanly. An abort overrides any
    // other error raised by the same byte so only one ERR pulse is issued.
    always_comb begin
        state_d     = state_q;
        nibHi_d     = nibHi_q;
        hold_d      = hold_q;
        holdValid_d = holdValid_q;
        holdFirst_d = holdFirst_q;
        count_d     = count_q;
        mData_d     = mData_q;
        mValid_d    = 1'b0;
        mSof_d      = 1'b0;
        mEof_d      = 1'b0;
        frameDone_d = 1'b0;
        frameLen_d  = frameLen_q;
        frameErr_d  = 1'b0;
        errCode_d   = errCode_q;
        errHit      = 1'b0;
        errSel      = ERR_NONE;
        newCount    = {1'b0, count_q} + 9'd1;

        if (RX_VALID_I) begin
            case (state_q)
                ST_IDLE: begin
                    if (RX_BYTE_I == SOF_CHAR) begin
                        state_d     = ST_HI;
                        count_d     = 8'h00;
                        holdValid_d = 1'b0;
                    end
                end
                ST_HI: begin
                    if (isHex) begin
                        nibHi_d = nibble;
                        state_d = ST_LO;
                    end else if (RX_BYTE_I == EOF_CHAR) begin
                        if (count_q == 8'h00) begin
                            errHit = 1'b1;
                            errSel = ERR_EMPTY;
                        end else begin
                            mData_d     = hold_q;
                            mValid_d    = 1'b1;
                            mSof_d      = holdFirst_q;
                            mEof_d      = 1'b1;
                            frameDone_d = 1'b1;
                            frameLen_d  = count_q;
                        end
                        holdValid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else if (RX_BYTE_I == SOF_CHAR) begin
                        errHit      = 1'b1;
                        errSel      = ERR_RESTART;
                        count_d     = 8'h00;
                        holdValid_d = 1'b0;
                        state_d     = ST_HI;
                    end else begin
                        errHit      = 1'b1;
                        errSel      = ERR_CHAR;
                        holdValid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                ST_LO: begin
                    if (isHex) begin
                        if (newCount > MAX_LIMIT) begin
                            errHit      = 1'b1;
                            errSel      = ERR_LEN;
                            holdValid_d = 1'b0;
                            state_d     = ST_IDLE;
                        end else begin
                            // Release the previous byte; it cannot be last.
                            if (holdValid_q) begin
                                mData_d  = hold_q;
                                mValid_d = 1'b1;
                                mSof_d   = holdFirst_q;
                            end
                            hold_d      = {nibHi_q, nibble};
                            holdFirst_d = ~holdValid_q;
                            holdValid_d = 1'b1;
                            count_d     = newCount[7:0];
                            state_d     = ST_HI;
                        end
                    end else if (RX_BYTE_I == EOF_CHAR) begin
                        errHit      = 1'b1;
                        errSel      = ERR_ODD;
                        holdValid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else if (RX_BYTE_I == SOF_CHAR) begin
                        errHit      = 1'b1;
                        errSel      = ERR_RESTART;
                        count_d     = 8'h00;
                        holdValid_d = 1'b0;
                        state_d     = ST_HI;
                    end else begin
                        errHit      = 1'b1;
                        errSel      = ERR_CHAR;
                        holdValid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    holdValid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            endcase
        end

        if (CS_RISE_I && (state_d != ST_IDLE)) begin
            errHit      = 1'b1;
            errSel      = ERR_ABORT;
            holdValid_d = 1'b0;
            state_d     = ST_IDLE;
        end

        if (errHit) begin
            frameErr_d = 1'b1;
            errCode_d  = errSel;
        end
    end

    assign M_DATA_O     = mData_q;
    assign M_VALID_O    = mValid_q;
    assign M_SOF_O      = mSof_q;
    assign M_EOF_O      = mEof_q;
    assign FRAME_DONE_O = frameDone_q;
    assign FRAME_LEN_O  = frameLen_q;
    assign FRAME_ERR_O  = frameErr_q;
    assign ERR_CODE_O   = errCode_q;
    assign BUSY_O       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_ascii_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_spi_ascii_frame_decoder
// Directed and randomized checks of the ASCII frame decoder. A byte-stream
// reference model builds the expected event list (beats, DONE, ERR) from the
// framing rules; a monitor records the events the decoder actually produces.
// A second instance with MAX_BYTES = 4 exercises the length limit.
// -----------------------------------------------------------------------------
module tb_spi_ascii_frame_decoder;
    import spi_frame_pkg::*;

    localparam int TB_MAX = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rxByte;
    logic       rxValid;
    logic       csRise;

    logic [7:0] mData, sData;
    logic       mValid, mSof, mEof, frameDone, frameErr, busy;
    logic       sValid, sSof, sEof, sDone, sErr, sBusy;
    logic [7:0] frameLen, sLen;
    logic [2:0] errCode, sCode;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] obsQ[$];
    logic [31:0] obsSmallQ[$];
    logic [31:0] expQ[$];
    logic [31:0] expSmallQ[$];

    // Reference model state: whole-frame view of the byte stream.
    bit         mInFrame;
    bit         mHaveHi;
    logic [3:0] mHiNib;
    logic [7:0] mFrameQ[$];
    logic [7:0] mLastLen;
    logic [2:0] mLastErr;

    spi_ascii_frame_decoder #(.MAX_BYTES(TB_MAX)) dut (
        .CLK_I(clk), .RST_I(rst), .RX_BYTE_I(rxByte), .RX_VALID_I(rxValid), .CS_RISE_I(csRise),
        .M_DATA_O(mData), .M_VALID_O(mValid), .M_SOF_O(mSof), .M_EOF_O(mEof),
        .FRAME_DONE_O(frameDone), .FRAME_LEN_O(frameLen), .FRAME_ERR_O(frameErr),
        .ERR_CODE_O(errCode), .BUSY_O(busy)
    );

    spi_ascii_frame_decoder #(.MAX_BYTES(4)) dutSmall (
        .CLK_I(clk), .RST_I(rst), .RX_BYTE_I(rxByte), .RX_VALID_I(rxValid), .CS_RISE_I(csRise),
        .M_DATA_O(sData), .M_VALID_O(sValid), .M_SOF_O(sSof), .M_EOF_O(sEof),
        .FRAME_DONE_O(sDone), .FRAME_LEN_O(sLen), .FRAME_ERR_O(sErr),
        .ERR_CODE_O(sCode), .BUSY_O(sBusy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [31:0] beatEv(input logic [7:0] d, input logic sof, input logic eof);
        return {2'd0, 12'd0, sof, eof, d, 8'h00};
    endfunction

    function automatic logic [31:0] doneEv(input logic [7:0] len);
        return {2'd1, 14'd0, 8'h00, len};
    endfunction

    function automatic logic [31:0] errEv(input logic [2:0] code);
        return {2'd2, 14'd0, 8'h00, 5'd0, code};
    endfunction

    // Record every output event half a cycle after the edge that produced it.
    always @(negedge clk) begin
        if (mValid)    obsQ.push_back(beatEv(mData, mSof, mEof));
        if (frameDone) obsQ.push_back(doneEv(frameLen));
        if (frameErr)  obsQ.push_back(errEv(errCode));
        if (sValid)    obsSmallQ.push_back(beatEv(sData, sSof, sEof));
        if (sDone)     obsSmallQ.push_back(doneEv(sLen));
        if (sErr)      obsSmallQ.push_back(errEv(sCode));
    end

    function automatic bit isHexChar(input logic [7:0] b);
        return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
    endfunction

    function automatic logic [3:0] hexVal(input logic [7:0] b);
        logic [7:0] v;
        if (b <= "9")      v = b - "0";
        else if (b >= "a") v = b - "a" + 8'd10;
        else               v = b - "A" + 8'd10;
        return v[3:0];
    endfunction

    function automatic logic [7:0] hexChar(input logic [3:0] n, input bit upper);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return (upper ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    task automatic modelReset();
        mInFrame = 0;
        mHaveHi  = 0;
        mFrameQ.delete();
        mLastLen = 8'h00;
        mLastErr = 3'd0;
    endtask

    // One input cycle of the reference model; appends expected events.
    task automatic modelStep(input logic [7:0] b, input logic v, input logic c);
        bit         errHit;
        logic [2:0] code;
        int         n;
        errHit = 0;
        code   = 3'd0;
        if (v) begin
            if (!mInFrame) begin
                if (b == 8'h23) begin
                    mInFrame = 1;
                    mHaveHi  = 0;
                    mFrameQ.delete();
                end
            end else if (isHexChar(b)) begin
                if (!mHaveHi) begin
                    mHiNib  = hexVal(b);
                    mHaveHi = 1;
                end else begin
                    mFrameQ.push_back({mHiNib, hexVal(b)});
                    mHaveHi = 0;
                    n = mFrameQ.size();
                    if (n > TB_MAX) begin
                        errHit = 1; code = 3'd3; mInFrame = 0;
                    end else if (n >= 2) begin
                        expQ.push_back(beatEv(mFrameQ[n-2], n == 2, 1'b0));
                    end
                end
            end else if (b == 8'h2F) begin
                n = mFrameQ.size();
                if (mHaveHi) begin
                    errHit = 1; code = 3'd2;
                end else if (n == 0) begin
                    errHit = 1; code = 3'd4;
                end else begin
                    expQ.push_back(beatEv(mFrameQ[n-1], n == 1, 1'b1));
                    expQ.push_back(doneEv(8'(n)));
                    mLastLen = 8'(n);
                end
                mInFrame = 0;
            end else if (b == 8'h23) begin
                errHit = 1; code = 3'd6;
                mFrameQ.delete();
                mHaveHi = 0;
            end else begin
                errHit = 1; code = 3'd1; mInFrame = 0;
            end
        end
        if (c && mInFrame) begin
            errHit = 1; code = 3'd5; mInFrame = 0;
        end
        if (errHit) begin
            expQ.push_back(errEv(code));
            mLastErr = code;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs and let the model see the same cycle.
    task automatic applyStimulus(input logic [7:0] b, input logic v, input logic c);
        rxByte  = b;
        rxValid = v;
        csRise  = c;
        modelStep(b, v, c);
        @(negedge clk);
        rxValid = 1'b0;
        csRise  = 1'b0;
    endtask

    task automatic sendChar(input logic [7:0] b);
        applyStimulus(b, 1'b1, 1'b0);
    endtask

    task automatic sendString(input string s);
        for (int i = 0; i < s.len(); i++) sendChar(s[i]);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, 1'b0);
    endtask

    task automatic applyReset();
        rst     = 1'b1;
        rxValid = 1'b0;
        csRise  = 1'b0;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic compareMain(input string tag);
        int n;
        checkOutput({tag, "_events"}, obsQ.size(), expQ.size());
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) checkOutput(tag, obsQ[i], expQ[i]);
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic compareSmall(input string tag);
        int n;
        checkOutput({tag, "_events"}, obsSmallQ.size(), expSmallQ.size());
        n = (obsSmallQ.size() < expSmallQ.size()) ? obsSmallQ.size() : expSmallQ.size();
        for (int i = 0; i < n; i++) checkOutput(tag, obsSmallQ[i], expSmallQ[i]);
        obsSmallQ.delete();
        expSmallQ.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, {mData, mValid, mSof, mEof, frameDone, frameLen, frameErr, errCode, busy}, 32'h0);
        checkOutput({tag, "_small"}, {sData, sValid, sSof, sEof, sDone, sLen, sErr, sCode, sBusy}, 32'h0);
    endtask

    // Random frame: optional idle garbage, then a frame that may be clean or
    // carry a bad char, odd nibble count, restart, CS abort or overlength.
    task automatic runRandomFrame();
        int          nGap, len, mode, pos;
        logic [7:0]  b;
        logic [7:0]  d;
        nGap = $urandom_range(0, 2);
        for (int i = 0; i < nGap; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h23) b = "x";
            sendChar(b);
        end
        sendChar("#");
        len  = ($urandom_range(0, 19) == 0) ? 65 : $urandom_range(1, 6);
        mode = $urandom_range(0, 9);
        pos  = $urandom_range(0, len - 1);
        for (int k = 0; k < len; k++) begin
            if (k == pos && mode == 0) sendChar("G");
            if (k == pos && mode == 2) sendChar("#");
            if (k == pos && mode == 3) applyStimulus(8'h00, 1'b0, 1'b1);
            d = 8'($urandom_range(0, 255));
            sendChar(hexChar(d[7:4], 1'($urandom_range(0, 1))));
            if ($urandom_range(0, 3) == 0) idleCycles(1);
            if (!(mode == 1 && k == len - 1)) sendChar(hexChar(d[3:0], 1'($urandom_range(0, 1))));
        end
        applyStimulus(8'h2F, 1'b1, 1'($urandom_range(0, 4) == 0));
    endtask

    // Directed scenarios followed by randomized frames.
    initial begin
        rst     = 1'b1;
        rxByte  = 8'h00;
        rxValid = 1'b0;
        csRise  = 1'b0;
        @(negedge clk);
        applyReset();
        checkAllZero("reset_state");

        sendString("#040100010400000000004444/");
        checkOutput("t1_last_beat", {mValid, mSof, mEof, frameDone, frameErr, mData, frameLen},
                    {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h44, 8'd12});
        idleCycles(2);
        compareMain("t1");
        checkOutput("t1_errcode", errCode, 3'd0);

        sendString("#0a/#AB/");
        checkOutput("t2_beat", {mValid, mSof, mEof, frameDone, mData, frameLen},
                    {1'b1, 1'b1, 1'b1, 1'b1, 8'hAB, 8'd1});
        idleCycles(2);
        compareMain("t2");

        sendString("#041/");
        checkOutput("t3_odd", {frameErr, mValid, errCode, busy}, {1'b1, 1'b0, 3'd2, 1'b0});
        sendString("#0G");
        checkOutput("t3_char", {frameErr, errCode, busy}, {1'b1, 3'd1, 1'b0});
        sendString("/#/");
        checkOutput("t3_empty", {frameErr, mValid, errCode}, {1'b1, 1'b0, 3'd4});
        idleCycles(2);
        compareMain("t3");

        applyReset();
        obsQ.delete();
        obsSmallQ.delete();
        sendString("#0102030405/");
        idleCycles(2);
        expSmallQ.push_back(beatEv(8'h01, 1'b1, 1'b0));
        expSmallQ.push_back(beatEv(8'h02, 1'b0, 1'b0));
        expSmallQ.push_back(beatEv(8'h03, 1'b0, 1'b0));
        expSmallQ.push_back(errEv(3'd3));
        compareSmall("t4_small");
        compareMain("t4");

        sendString("#0102#");
        checkOutput("t5_restart", {frameErr, errCode, busy}, {1'b1, 3'd6, 1'b1});
        sendString("33/");
        checkOutput("t5_beat", {mValid, mSof, mEof, frameDone, mData, frameLen},
                    {1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 8'd1});
        idleCycles(2);
        compareMain("t5");

        sendString("#0102");
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("t6_abort", {frameErr, errCode, busy}, {1'b1, 3'd5, 1'b0});
        sendString("#12");
        applyStimulus(8'h2F, 1'b1, 1'b1);
        checkOutput("t6_eof_cs", {frameDone, frameErr, mEof, mData}, {1'b1, 1'b0, 1'b1, 8'h12});
        idleCycles(2);
        compareMain("t6");

        sendString("#ab");
        applyReset();
        checkAllZero("t6_reset");
        obsQ.delete();
        sendString("#5A/");
        idleCycles(2);
        compareMain("t6_after_reset");
        checkOutput("t6_len", frameLen, 8'd1);

        applyReset();
        obsQ.delete();
        obsSmallQ.delete();
        for (int f = 0; f < 40; f++) runRandomFrame();
        idleCycles(2);
        compareMain("random");
        checkOutput("random_len_held", frameLen, mLastLen);
        checkOutput("random_code_held", errCode, mLastErr);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
